sm_motion_sequencer: RTL and testbench

Motion controller that sequences the stepper-motor pulse generator. It accepts one move command at a time through a valid/ready handshake. It then drives the generator's enable and period inputs with a linear acceleration/deceleration ramp, counts emitted steps via a per-step tick fed back from the generator, and reports done/fault. It supports finite moves (N steps) and continuous moves (run until stop), plus immediate abort and limit-switch shutdown.

---
 rtl/sm_motion_pkg.sv | 27 ++
 rtl/sm_ramp_period.sv | 49 ++++
 rtl/sm_motion_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_sm_motion_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_motion_pkg.sv
// ============================================================================
// Module   : sm_motion_pkg
// Purpose  : Shared state encoding and default constants for the motion
//            sequencer and its ramp helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sm_motion_pkg;

   localparam int DEF_SIZE         = 16;
   localparam int DEF_CNT_W        = 24;
   localparam int DEF_START_PERIOD = 2000;
   localparam int DEF_MIN_PERIOD   = 200;
   localparam int DEF_RAMP_STEP    = 100;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCEL  = 3'd1,
      ST_CRUISE = 3'd2,
      ST_DECEL  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sm_ramp_period.sv
// ============================================================================
// Module   : sm_ramp_period
// Purpose  : Saturating one-step period update: down towards target while
//            accelerating, up towards START_PERIOD while decelerating.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_ramp_period
   import sm_motion_pkg::*;
#(
   parameter int SIZE         = DEF_SIZE,
   parameter int START_PERIOD = DEF_START_PERIOD,
   parameter int RAMP_STEP    = DEF_RAMP_STEP
) (
   input  logic            up,
   input  logic [SIZE-1:0] period_cur,
   input  logic [SIZE-1:0] target,
   output logic [SIZE-1:0] period_next,
   output logic            reached
);

   localparam logic [SIZE-1:0] C_START = SIZE'(START_PERIOD);
   localparam logic [SIZE-1:0] C_STEP  = SIZE'(RAMP_STEP);

   always_comb begin
      period_next = period_cur;
      reached     = 1'b0;
      if (up) begin
         if ((period_cur >= C_START) || ((C_START - period_cur) <= C_STEP)) begin
            period_next = C_START;
         end else begin
            period_next = period_cur + C_STEP;
         end
         reached = (period_next == C_START);
      end else begin
         // Clamp at target rather than stepping past it.
         if ((period_cur <= target) || ((period_cur - target) <= C_STEP)) begin
            period_next = target;
         end else begin
            period_next = period_cur - C_STEP;
         end
         reached = (period_next == target);
      end
   end

endmodule

`default_nettype wire

// File: rtl/sm_motion_sequencer.sv
// ============================================================================
// Module   : sm_motion_sequencer
// Purpose  : Accepts move commands and drives the stepper pulse generator with
//            a linear accel/cruise/decel ramp, counting steps from step_tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_motion_sequencer
   import sm_motion_pkg::*;
#(
   parameter int SIZE         = DEF_SIZE,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int START_PERIOD = DEF_START_PERIOD,
   parameter int MIN_PERIOD   = DEF_MIN_PERIOD,
   parameter int RAMP_STEP    = DEF_RAMP_STEP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [SIZE-1:0]  cmd_period,
   input  logic             cmd_dir,
   input  logic             cmd_continuous,
   input  logic             stop,
   input  logic             abort,
   input  logic             limit,
   input  logic             step_tick,
   output logic             drv_en_SM,
   output logic [SIZE-1:0]  drv_period,
   output logic             drv_dir,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [CNT_W-1:0] steps_left
);

   localparam logic [SIZE-1:0]  C_START   = SIZE'(START_PERIOD);
   localparam logic [SIZE-1:0]  C_MIN     = SIZE'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   state_t             state_q, state_d;
   logic [SIZE-1:0]    target_q, target_d;
   logic               dir_q, dir_d;
   logic               cont_q, cont_d;
   logic [CNT_W-1:0]   steps_left_q, steps_left_d;
   logic [CNT_W-1:0]   ramp_cnt_q, ramp_cnt_d;
   logic               drv_en_q, drv_en_d;
   logic [SIZE-1:0]    drv_period_q, drv_period_d;
   logic               fault_q, fault_d;

   logic [SIZE-1:0]    cmd_target;
   logic [CNT_W-1:0]   steps_dec;
   logic [CNT_W-1:0]   ramp_inc;
   logic [CNT_W-1:0]   ramp_dec;
   logic               finite_end;
   logic [SIZE-1:0]    ramp_period;
   logic               ramp_reached;

   assign cmd_target = (cmd_period < C_MIN) ? C_MIN : cmd_period;
   assign steps_dec  = (cont_q || (steps_left_q == '0)) ? steps_left_q : steps_left_q - C_CNT_ONE;
   assign ramp_inc   = (&ramp_cnt_q) ? ramp_cnt_q : ramp_cnt_q + C_CNT_ONE;
   assign ramp_dec   = (ramp_cnt_q == '0) ? ramp_cnt_q : ramp_cnt_q - C_CNT_ONE;
   assign finite_end = !cont_q && (steps_dec == '0);

   sm_ramp_period #(
      .SIZE         (SIZE),
      .START_PERIOD (START_PERIOD),
      .RAMP_STEP    (RAMP_STEP)
   ) u_ramp (
      .up          (state_q == ST_DECEL),
      .period_cur  (drv_period_q),
      .target      (target_q),
      .period_next (ramp_period),
      .reached     (ramp_reached)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         target_q     <= C_START;
         dir_q        <= 1'b0;
         cont_q       <= 1'b0;
         steps_left_q <= '0;
         ramp_cnt_q   <= '0;
         drv_en_q     <= 1'b0;
         drv_period_q <= C_START;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         target_q     <= target_d;
         dir_q        <= dir_d;
         cont_q       <= cont_d;
         steps_left_q <= steps_left_d;
         ramp_cnt_q   <= ramp_cnt_d;
         drv_en_q     <= drv_en_d;
         drv_period_q <= drv_period_d;
         fault_q      <= fault_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      target_d     = target_q;
      dir_d        = dir_q;
      cont_d       = cont_q;
      steps_left_d = steps_left_q;
      ramp_cnt_d   = ramp_cnt_q;
      drv_en_d     = drv_en_q;
      drv_period_d = drv_period_q;
      fault_d      = fault_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               target_d     = cmd_target;
               dir_d        = cmd_dir;
               cont_d       = cmd_continuous;
               steps_left_d = cmd_steps;
               ramp_cnt_d   = '0;
               fault_d      = 1'b0;
               if (!cmd_continuous && (cmd_steps == '0)) begin
                  state_d      = ST_DONE;
                  drv_en_d     = 1'b0;
                  drv_period_d = C_START;
               end else if (cmd_target < C_START) begin
                  state_d      = ST_ACCEL;
                  drv_en_d     = 1'b1;
                  drv_period_d = C_START;
               end else begin
                  state_d      = ST_CRUISE;
                  drv_en_d     = 1'b1;
                  drv_period_d = cmd_target;
               end
            end
         end

         ST_ACCEL, ST_CRUISE, ST_DECEL: begin
            if (abort || limit) begin
               state_d      = ST_DONE;
               drv_en_d     = 1'b0;
               drv_period_d = C_START;
               if (limit) begin
                  fault_d = 1'b1;
               end
            end else if (stop && (state_q != ST_DECEL)) begin
               // With no ramp built up there is nothing to decelerate through.
               if (ramp_cnt_q == '0) begin
                  state_d      = ST_DONE;
                  drv_en_d     = 1'b0;
                  drv_period_d = C_START;
               end else begin
                  state_d = ST_DECEL;
               end
            end else if (step_tick) begin
               steps_left_d = steps_dec;
               if (state_q == ST_ACCEL) begin
                  drv_period_d = ramp_period;
                  ramp_cnt_d   = ramp_inc;
                  if (!cont_q && (steps_dec <= ramp_inc)) begin
                     state_d = ST_DECEL;
                  end else if (ramp_reached) begin
                     state_d = ST_CRUISE;
                  end
               end else if (state_q == ST_CRUISE) begin
                  if (!cont_q && (steps_dec <= ramp_cnt_q)) begin
                     state_d = ST_DECEL;
                  end
               end else begin
                  drv_period_d = ramp_period;
                  ramp_cnt_d   = ramp_dec;
                  if (ramp_dec == '0) begin
                     state_d = ST_DONE;
                  end
               end
               if (finite_end || (state_d == ST_DONE)) begin
                  state_d      = ST_DONE;
                  drv_en_d     = 1'b0;
                  drv_period_d = C_START;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign cmd_ready  = (state_q == ST_IDLE) && !rst;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign drv_en_SM  = drv_en_q;
   assign drv_period = drv_period_q;
   assign drv_dir    = dir_q;
   assign fault      = fault_q;
   assign steps_left = steps_left_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_motion_sequencer.sv
// ============================================================================
// Module   : tb_sm_motion_sequencer
// Purpose  : Directed self-checking bench for sm_motion_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_motion_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [23:0] cmd_steps;
   logic [15:0] cmd_period;
   logic        cmd_dir;
   logic        cmd_continuous;
   logic        stop;
   logic        abort;
   logic        limit;
   logic        step_tick;
   logic        drv_en_SM;
   logic [15:0] drv_period;
   logic        drv_dir;
   logic        busy;
   logic        done;
   logic        fault;
   logic [23:0] steps_left;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sm_motion_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_steps      (cmd_steps),
      .cmd_period     (cmd_period),
      .cmd_dir        (cmd_dir),
      .cmd_continuous (cmd_continuous),
      .stop           (stop),
      .abort          (abort),
      .limit          (limit),
      .step_tick      (step_tick),
      .drv_en_SM      (drv_en_SM),
      .drv_period     (drv_period),
      .drv_dir        (drv_dir),
      .busy           (busy),
      .done           (done),
      .fault          (fault),
      .steps_left     (steps_left)
   );

   // Advance one clock and settle just after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input int steps, input int period, input logic dir, input logic cont);
      cmd_steps      = 24'(steps);
      cmd_period     = 16'(period);
      cmd_dir        = dir;
      cmd_continuous = cont;
      cmd_valid      = 1'b1;
      cyc();
      cmd_valid      = 1'b0;
   endtask

   task automatic pulse_tick();
      step_tick = 1'b1;
      cyc();
      step_tick = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      n_chk++;
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b expected 0", cmd_ready); end
      n_chk++;
      if ({drv_en_SM, drv_dir, busy, done, fault} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 00000", {drv_en_SM, drv_dir, busy, done, fault});
      end
      n_chk++;
      if (drv_period !== 16'd2000) begin n_fail++; $display("FAIL reset_period: got %0d expected 2000", drv_period); end
      n_chk++;
      if (steps_left !== 24'd0) begin n_fail++; $display("FAIL reset_steps: got %0d expected 0", steps_left); end
      rst = 1'b0;
      cyc();
      n_chk++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", cmd_ready); end
   endtask

   task automatic test_finite();
      int exp_p [9] = '{1900, 1800, 1700, 1600, 1500, 1600, 1700, 1800, 1900};
      send_cmd(10, 1500, 1'b1, 1'b0);
      n_chk++;
      if ({drv_en_SM, drv_dir, busy, cmd_ready} !== 4'b1110) begin
         n_fail++; $display("FAIL fin_start_flags: got %b expected 1110", {drv_en_SM, drv_dir, busy, cmd_ready});
      end
      n_chk++;
      if (drv_period !== 16'd2000 || steps_left !== 24'd10) begin
         n_fail++; $display("FAIL fin_start_vals: got period %0d steps %0d expected 2000 10", drv_period, steps_left);
      end
      for (int i = 0; i < 9; i++) begin
         pulse_tick();
         n_chk++;
         if (drv_period !== 16'(exp_p[i]) || steps_left !== 24'(9 - i) || done !== 1'b0) begin
            n_fail++;
            $display("FAIL fin_tick%0d: got period %0d steps %0d done %b expected %0d %0d 0",
                     i + 1, drv_period, steps_left, done, exp_p[i], 9 - i);
         end
      end
      pulse_tick();
      n_chk++;
      if ({done, drv_en_SM, busy} !== 3'b101 || drv_period !== 16'd2000) begin
         n_fail++; $display("FAIL fin_done: got done/en/busy %b period %0d expected 101 2000", {done, drv_en_SM, busy}, drv_period);
      end
      cyc();
      n_chk++;
      if ({done, busy, cmd_ready} !== 3'b001) begin
         n_fail++; $display("FAIL fin_idle: got done/busy/ready %b expected 001", {done, busy, cmd_ready});
      end
   endtask

   task automatic test_triangle();
      int exp_p [3] = '{1900, 1800, 1900};
      send_cmd(4, 50, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         pulse_tick();
         n_chk++;
         if (drv_period !== 16'(exp_p[i]) || done !== 1'b0 || drv_en_SM !== 1'b1) begin
            n_fail++; $display("FAIL tri_tick%0d: got period %0d done %b en %b expected %0d 0 1",
                               i + 1, drv_period, done, drv_en_SM, exp_p[i]);
         end
      end
      pulse_tick();
      n_chk++;
      if ({done, drv_en_SM} !== 2'b10) begin n_fail++; $display("FAIL tri_done: got done/en %b expected 10", {done, drv_en_SM}); end
      cyc();
   endtask

   task automatic test_continuous();
      send_cmd(0, 1800, 1'b0, 1'b1);
      pulse_tick();
      pulse_tick();
      n_chk++;
      if (drv_period !== 16'd1800 || busy !== 1'b1) begin
         n_fail++; $display("FAIL cont_accel: got period %0d busy %b expected 1800 1", drv_period, busy);
      end
      pulse_tick();
      pulse_tick();
      n_chk++;
      if (drv_period !== 16'd1800 || done !== 1'b0 || drv_en_SM !== 1'b1) begin
         n_fail++; $display("FAIL cont_cruise: got period %0d done %b en %b expected 1800 0 1", drv_period, done, drv_en_SM);
      end
      stop = 1'b1;
      cyc();
      pulse_tick();
      n_chk++;
      if (drv_period !== 16'd1900 || done !== 1'b0) begin
         n_fail++; $display("FAIL cont_decel1: got period %0d done %b expected 1900 0", drv_period, done);
      end
      pulse_tick();
      n_chk++;
      if (drv_period !== 16'd2000 || {done, drv_en_SM} !== 2'b10) begin
         n_fail++; $display("FAIL cont_decel2: got period %0d done/en %b expected 2000 10", drv_period, {done, drv_en_SM});
      end
      stop = 1'b0;
      cyc();
      send_cmd(0, 2500, 1'b0, 1'b1);
      n_chk++;
      if (drv_period !== 16'd2500 || drv_en_SM !== 1'b1) begin
         n_fail++; $display("FAIL slow_cruise: got period %0d en %b expected 2500 1", drv_period, drv_en_SM);
      end
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      n_chk++;
      if ({done, drv_en_SM} !== 2'b10) begin n_fail++; $display("FAIL slow_stop: got done/en %b expected 10", {done, drv_en_SM}); end
      cyc();
   endtask

   task automatic test_zero_steps();
      send_cmd(0, 1000, 1'b0, 1'b0);
      n_chk++;
      if ({done, drv_en_SM, busy, cmd_ready} !== 4'b1010) begin
         n_fail++; $display("FAIL zero_done: got done/en/busy/ready %b expected 1010", {done, drv_en_SM, busy, cmd_ready});
      end
      cyc();
      n_chk++;
      if ({done, drv_en_SM, busy, cmd_ready} !== 4'b0001) begin
         n_fail++; $display("FAIL zero_idle: got done/en/busy/ready %b expected 0001", {done, drv_en_SM, busy, cmd_ready});
      end
   endtask

   task automatic test_limit_abort();
      send_cmd(5, 2500, 1'b1, 1'b0);
      pulse_tick();
      n_chk++;
      if (drv_period !== 16'd2500 || steps_left !== 24'd4) begin
         n_fail++; $display("FAIL lim_cruise: got period %0d steps %0d expected 2500 4", drv_period, steps_left);
      end
      limit = 1'b1;
      cyc();
      limit = 1'b0;
      n_chk++;
      if ({drv_en_SM, fault, done} !== 3'b011) begin
         n_fail++; $display("FAIL lim_stop: got en/fault/done %b expected 011", {drv_en_SM, fault, done});
      end
      cyc();
      n_chk++;
      if ({fault, busy} !== 2'b10) begin n_fail++; $display("FAIL lim_sticky: got fault/busy %b expected 10", {fault, busy}); end
      send_cmd(5, 2500, 1'b0, 1'b0);
      n_chk++;
      if ({fault, drv_en_SM} !== 2'b01) begin n_fail++; $display("FAIL fault_clear: got fault/en %b expected 01", {fault, drv_en_SM}); end
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      n_chk++;
      if ({drv_en_SM, fault, done} !== 3'b001) begin
         n_fail++; $display("FAIL abort_stop: got en/fault/done %b expected 001", {drv_en_SM, fault, done});
      end
      cyc();
   endtask

   task automatic test_busy_and_rst();
      send_cmd(20, 1500, 1'b0, 1'b0);
      cmd_steps = 24'd3;
      cmd_dir   = 1'b1;
      cmd_valid = 1'b1;
      cyc();
      cmd_valid = 1'b0;
      n_chk++;
      if (steps_left !== 24'd20 || drv_dir !== 1'b0 || cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL busy_ignore: got steps %0d dir %b ready %b expected 20 0 0", steps_left, drv_dir, cmd_ready);
      end
      pulse_tick();
      n_chk++;
      if (drv_period !== 16'd1900) begin n_fail++; $display("FAIL busy_accel: got period %0d expected 1900", drv_period); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      n_chk++;
      if ({drv_en_SM, busy, done, fault} !== 4'b0 || drv_period !== 16'd2000 || steps_left !== 24'd0) begin
         n_fail++; $display("FAIL rst_mid: got en/busy/done/fault %b period %0d steps %0d expected 0000 2000 0",
                            {drv_en_SM, busy, done, fault}, drv_period, steps_left);
      end
      cyc();
      n_chk++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_ready: got ready %b busy %b expected 1 0", cmd_ready, busy);
      end
   endtask

   initial begin
      rst            = 1'b1;
      cmd_valid      = 1'b0;
      cmd_steps      = '0;
      cmd_period     = '0;
      cmd_dir        = 1'b0;
      cmd_continuous = 1'b0;
      stop           = 1'b0;
      abort          = 1'b0;
      limit          = 1'b0;
      step_tick      = 1'b0;

      test_reset();
      test_finite();
      test_triangle();
      test_continuous();
      test_zero_steps();
      test_limit_abort();
      test_busy_and_rst();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
